// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Single-outstanding load/store responder backed by a small
//                word-addressed memory, with a fixed programmable response
//                latency and misaligned / out-of-range error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        resp_ready
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_txn_write;
  logic [31:0]   w_txn_addr;
  logic [31:0]   w_txn_wdata;
  logic [AW-1:0] w_txn_idx;
  logic          w_txn_err;

  // Ready is gated by reset so it reads 0 while the block is held in reset.
  assign req_ready  = (state_q == IDLE) && rst;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Transaction view: live request when entering RESP straight from IDLE
  // (LATENCY=1), otherwise the fields latched at accept.
  always_comb begin
    w_txn_write = write_q;
    w_txn_addr  = addr_q;
    w_txn_wdata = wdata_q;
    if (state_q == IDLE) begin
      w_txn_write = req_write;
      w_txn_addr  = req_addr;
      w_txn_wdata = req_wdata;
    end
    w_txn_idx = w_txn_addr[AW+1:2];
    w_txn_err = (w_txn_addr[1:0] != 2'b00) || (w_txn_addr[31:2] >= 30'(DEPTH));
  end

  // Next-state, latency counter and response capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    w_enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY <= 1) begin
            state_d      = RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Memory is accessed on the edge that enters RESP.
    if (w_enter_resp) begin
      err_d   = w_txn_err;
      rdata_d = (w_txn_write || w_txn_err) ? 32'h0 : mem_q[w_txn_idx];
    end
  end

  // Control and response registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage: cleared by reset, written by a valid store entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (w_enter_resp && w_txn_write && !w_txn_err) begin
      mem_q[w_txn_idx] <= w_txn_wdata;
    end
  end

endmodule
`default_nettype wire
